// File: rtl/pu_riscv_verilog_pkg.sv
// rtl/pu_riscv_verilog_pkg.sv - shared branch-predictor types, counter encodings and update helper
package pu_riscv_verilog_pkg;

  typedef enum logic {BHT_INIT, BHT_RUN} bht_state_t;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == BP_ST) ? BP_ST : cnt + 2'b01;
    else       return (cnt == BP_SNT) ? BP_SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/pu_riscv_bp_ram.sv
// rtl/pu_riscv_bp_ram.sv - 2-bit wide simple dual-port RAM with registered, enable-held read port
module pu_riscv_bp_ram #(
  parameter int IDX = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_we,
  input  logic [IDX-1:0] i_waddr,
  input  logic [1:0]     i_wdata,
  input  logic           i_re,
  input  logic [IDX-1:0] i_raddr,
  output logic [1:0]     o_rdata
);

  localparam int DEPTH = 2**IDX;

  logic [1:0] r_mem [DEPTH];
  logic [1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds when i_re is low; reset gives the 00 idle prediction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= 2'b00;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pu_riscv_bp_bht.sv
// rtl/pu_riscv_bp_bht.sv - branch history table: clear FSM, counter update write mux, write-first read bypass
module pu_riscv_bp_bht
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_stall,
  input  logic [XLEN-1:0]           if_pc,
  output logic [1:0]                bp_bp_predict,
  output logic                      bp_init_busy,
  input  logic [XLEN-1:0]           bu_pc,
  input  logic                      bu_bp_update,
  input  logic [1:0]                bu_bp_predict,
  input  logic                      bu_bp_btaken,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history
);

  localparam int IDX = BP_GLOBAL_BITS + BP_LOCAL_BITS;

  bht_state_t     r_state, w_next_state;
  logic [IDX-1:0] r_init_cnt;
  logic           r_byp;
  logic [1:0]     r_byp_cnt;

  logic           w_run, w_upd, w_collide, w_we, w_re;
  logic [IDX-1:0] w_rd_idx, w_wr_idx, w_waddr;
  logic [1:0]     w_upd_cnt, w_wdata, w_ram_q;
  logic           w_unused_pc_bits;

  assign w_rd_idx = {bu_bp_history, if_pc[BP_LOCAL_BITS+1:2]};
  assign w_wr_idx = {bu_bp_history, bu_pc[BP_LOCAL_BITS+1:2]};
  assign w_unused_pc_bits = ^{if_pc[XLEN-1:BP_LOCAL_BITS+2], if_pc[1:0],
                              bu_pc[XLEN-1:BP_LOCAL_BITS+2], bu_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BHT_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == BHT_INIT) r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    bp_init_busy = 1'b0;
    case (r_state)
      BHT_INIT: begin
        bp_init_busy = 1'b1;
        if (r_init_cnt == {IDX{1'b1}}) w_next_state = BHT_RUN;
      end
      default: w_next_state = BHT_RUN;
    endcase
  end

  assign w_run     = (r_state == BHT_RUN);
  assign w_upd     = w_run & bu_bp_update;
  assign w_upd_cnt = bp_sat_update(bu_bp_predict, bu_bp_btaken);

  // During the clear sweep the write port belongs to the init counter.
  assign w_we    = ~w_run | bu_bp_update;
  assign w_waddr = w_run ? w_wr_idx  : r_init_cnt;
  assign w_wdata = w_run ? w_upd_cnt : BP_WNT;

  assign w_re      = w_run & ~if_stall;
  assign w_collide = w_upd & (w_rd_idx == w_wr_idx);

  // RAM reads the old value on a same-index write; remember to substitute the new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp     <= 1'b0;
      r_byp_cnt <= BP_SNT;
    end else if (w_re) begin
      r_byp     <= w_collide;
      r_byp_cnt <= w_upd_cnt;
    end
  end

  pu_riscv_bp_ram #(.IDX(IDX)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_q)
  );

  assign bp_bp_predict = r_byp ? r_byp_cnt : w_ram_q;

endmodule

// File: tb/tb_pu_riscv_bp_bht.sv
// tb/tb_pu_riscv_bp_bht.sv - directed and randomized checks of the BHT against a table model
module tb_pu_riscv_bp_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall;
  logic [63:0] if_pc;
  logic [1:0]  bp_bp_predict;
  logic        bp_init_busy;
  logic [63:0] bu_pc;
  logic        bu_bp_update;
  logic [1:0]  bu_bp_predict;
  logic        bu_bp_btaken;
  logic [1:0]  bu_bp_history;

  int          mdl [4096];
  logic [1:0]  exp_q;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] PC_A = 64'h8000_0010;
  localparam logic [63:0] PC_B = 64'h8000_0100;
  localparam logic [63:0] PC_C = 64'h8000_0200;
  localparam logic [63:0] PC_D = 64'h8000_0300;

  always #5 clk = ~clk;

  pu_riscv_bp_bht dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .if_pc         (if_pc),
    .bp_bp_predict (bp_bp_predict),
    .bp_init_busy  (bp_init_busy),
    .bu_pc         (bu_pc),
    .bu_bp_update  (bu_bp_update),
    .bu_bp_predict (bu_bp_predict),
    .bu_bp_btaken  (bu_bp_btaken),
    .bu_bp_history (bu_bp_history)
  );

  function automatic int tbl_idx(input logic [1:0] hist, input logic [63:0] pc);
    return int'(hist) * 1024 + int'((pc % 64'd4096) / 64'd4);
  endfunction

  function automatic int sat(input int cnt, input logic taken);
    if (taken) return (cnt >= 3) ? 3 : cnt + 1;
    return (cnt <= 0) ? 0 : cnt - 1;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step(input logic stall, input logic [63:0] pc, input logic upd,
                      input logic [63:0] bpc, input logic [1:0] pred, input logic taken,
                      input logic [1:0] hist);
    @(negedge clk);
    if_stall = stall; if_pc = pc; bu_bp_update = upd; bu_pc = bpc;
    bu_bp_predict = pred; bu_bp_btaken = taken; bu_bp_history = hist;
    @(posedge clk);
    #1;
    if (upd) mdl[tbl_idx(hist, bpc)] = sat(int'(pred), taken);
    if (!stall) exp_q = 2'(mdl[tbl_idx(hist, pc)]);
    check("model", bp_bp_predict, exp_q);
  endtask

  // Called at the negedge where rst was released; inputs try to update while busy.
  task automatic sweep(input string tag);
    int n = 0;
    bu_bp_update = 1'b1; bu_pc = PC_A; bu_bp_predict = 2'b11; bu_bp_btaken = 1'b1;
    if_stall = 1'b0; if_pc = PC_A; bu_bp_history = 2'b00;
    while (bp_init_busy === 1'b1 && n < 5000) begin
      n++;
      if (bp_bp_predict !== 2'b00) check({tag, "_init_pred"}, bp_bp_predict, 2'b00);
      @(negedge clk);
    end
    bu_bp_update = 1'b0;
    checks++;
    assert (n == 4096) else begin
      errors++;
      $error("FAIL %s_busy_cycles observed=%0d expected=4096", tag, n);
    end
    for (int i = 0; i < 4096; i++) mdl[i] = 1;
    exp_q = 2'b00;
    check({tag, "_busy_low"}, {1'b0, bp_init_busy}, 2'b00);
    check({tag, "_pred_after"}, bp_bp_predict, 2'b00);
  endtask

  initial begin
    logic [1:0] held;
    rst = 1'b1; if_stall = 1'b0; if_pc = '0; bu_pc = '0; bu_bp_update = 1'b0;
    bu_bp_predict = 2'b00; bu_bp_btaken = 1'b0; bu_bp_history = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_busy", {1'b0, bp_init_busy}, 2'b01);
    check("reset_pred", bp_bp_predict, 2'b00);
    rst = 1'b0;
    sweep("clear");

    for (int i = 0; i < 6; i++) begin
      step(1'b0, 64'h8000_0000 + 64'($urandom_range(0, 4095)), 1'b0, 64'h0, 2'b00, 1'b0,
           2'($urandom_range(0, 3)));
      check("cleared_lookup", bp_bp_predict, 2'b01);
    end

    begin
      logic [1:0] up_pred [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
      logic [1:0] up_exp  [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
      logic [1:0] dn_pred [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
      logic [1:0] dn_exp  [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 4; i++) begin
        step(1'b0, PC_A, 1'b1, PC_A, up_pred[i], 1'b1, 2'b00);
        check("sat_up", bp_bp_predict, up_exp[i]);
      end
      step(1'b0, PC_A, 1'b0, PC_A, 2'b00, 1'b0, 2'b00);
      check("sat_up_lookup", bp_bp_predict, 2'b11);
      step(1'b0, PC_A, 1'b1, PC_A, 2'b11, 1'b1, 2'b00);
      check("sat_up_fifth", bp_bp_predict, 2'b11);
      for (int i = 0; i < 4; i++) begin
        step(1'b0, PC_A, 1'b1, PC_A, dn_pred[i], 1'b0, 2'b00);
        check("sat_down", bp_bp_predict, dn_exp[i]);
      end
    end

    step(1'b0, PC_B, 1'b1, PC_B, 2'b01, 1'b1, 2'b00);
    check("collision", bp_bp_predict, 2'b10);

    step(1'b0, PC_A, 1'b1, 64'h8000_0012, 2'b01, 1'b1, 2'b11);
    step(1'b0, PC_A, 1'b0, PC_A, 2'b00, 1'b0, 2'b11);
    check("alias", bp_bp_predict, 2'b10);

    step(1'b0, PC_A, 1'b1, PC_C, 2'b01, 1'b1, 2'b01);
    step(1'b0, PC_C, 1'b0, PC_C, 2'b00, 1'b0, 2'b10);
    check("hist_other", bp_bp_predict, 2'b01);
    step(1'b0, PC_C, 1'b0, PC_C, 2'b00, 1'b0, 2'b01);
    check("hist_same", bp_bp_predict, 2'b10);

    held = bp_bp_predict;
    step(1'b1, PC_A, 1'b1, PC_D, 2'b01, 1'b0, 2'b00);
    check("stall_hold", bp_bp_predict, held);
    step(1'b1, PC_D, 1'b0, PC_D, 2'b00, 1'b0, 2'b00);
    check("stall_hold", bp_bp_predict, held);
    step(1'b1, PC_B, 1'b0, PC_D, 2'b00, 1'b0, 2'b00);
    check("stall_hold", bp_bp_predict, held);
    step(1'b0, PC_D, 1'b0, PC_D, 2'b00, 1'b0, 2'b00);
    check("stall_write", bp_bp_predict, 2'b00);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] rpc, wpc;
      logic [1:0]  hist, pred;
      hist = 2'($urandom_range(0, 3));
      rpc  = 64'h8000_0000 + 64'($urandom_range(0, 7) * 4) + 64'($urandom_range(0, 3));
      wpc  = 64'h8000_0000 + 64'($urandom_range(0, 7) * 4) + 64'($urandom_range(0, 3));
      pred = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(mdl[tbl_idx(hist, wpc)]);
      step($urandom_range(0, 4) == 0, rpc, $urandom_range(0, 2) != 0, wpc, pred,
           1'($urandom_range(0, 1)), hist);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", {1'b0, bp_init_busy}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pulse_busy", {1'b0, bp_init_busy}, 2'b01);
    check("rst_pulse_pred", bp_bp_predict, 2'b00);
    rst = 1'b0;
    sweep("restart");
    step(1'b0, PC_A, 1'b0, PC_A, 2'b00, 1'b0, 2'b00);
    check("restart_lookup", bp_bp_predict, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
